// File: rtl/pipe_pkg.sv
// Shared EX/MEM pipeline types: default field widths, memory-control pair and
// the full slot record carried from the EX stage towards data memory.
package pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int REG_W_DEF  = 5;
  localparam int WB_W_DEF   = 2;
  localparam int STAGES_MAX = 4;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
  } mem_ctrl_t;

  typedef struct packed {
    logic                  valid;
    logic [WB_W_DEF-1:0]   ctrl_wb;
    mem_ctrl_t             mem_ctrl;
    logic [DATA_W_DEF-1:0] alu_result;
    logic [DATA_W_DEF-1:0] store_data;
    logic [REG_W_DEF-1:0]  rd;
  } ex_mem_slot_t;

endpackage

// File: rtl/pipe_slot.sv
// One EX/MEM slot register. Reset clears everything; flush kills only the
// valid/control bits so a dead entry can never write back or store.
module pipe_slot
  import pipe_pkg::*;
#(
  parameter type slot_t = ex_mem_slot_t
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  i_flush,
  input  logic  i_stall,
  input  slot_t i_d,
  output slot_t o_q
);

  slot_t r_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_flush) begin
      r_q.valid    <= 1'b0;
      r_q.ctrl_wb  <= '0;
      r_q.mem_ctrl <= '0;
    end else if (!i_stall) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/ex_mem_pipe_stage.sv
// EX->MEM pipeline register with 1..4 slots in series, bubble gating, flush,
// load-in-flight detection and saturating stall/flush event counters.
module ex_mem_pipe_stage
  import pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int REG_W  = REG_W_DEF,
  parameter int WB_W   = WB_W_DEF,
  parameter int STAGES = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [WB_W-1:0]   ctrl_wb_i,
  input  logic              mem_write_i,
  input  logic              mem_read_i,
  input  logic [DATA_W-1:0] alu_result_i,
  input  logic [DATA_W-1:0] store_data_i,
  input  logic [REG_W-1:0]  rd_i,
  output logic              valid_o,
  output logic [WB_W-1:0]   ctrl_wb_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  output logic [DATA_W-1:0] alu_result_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [REG_W-1:0]  rd_o,
  output logic              load_busy_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  typedef struct packed {
    logic              valid;
    logic [WB_W-1:0]   ctrl_wb;
    mem_ctrl_t         mem_ctrl;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] store_data;
    logic [REG_W-1:0]  rd;
  } slot_t;

  generate
    if (STAGES < 1 || STAGES > STAGES_MAX) begin : g_bad_stages
      $error("ex_mem_pipe_stage: STAGES must be in 1..4");
    end
  endgenerate

  slot_t            w_in;
  slot_t            w_slot_d [STAGES];
  slot_t            w_slot_q [STAGES];
  logic             w_load_busy;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  // Bubbles still carry data/rd but never any control that could commit.
  always_comb begin
    w_in            = '0;
    w_in.alu_result = alu_result_i;
    w_in.store_data = store_data_i;
    w_in.rd         = rd_i;
    if (valid_i) begin
      w_in.valid              = 1'b1;
      w_in.ctrl_wb            = ctrl_wb_i;
      w_in.mem_ctrl.mem_read  = mem_read_i;
      w_in.mem_ctrl.mem_write = mem_write_i;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_slot
      if (gi == 0) begin : g_head
        assign w_slot_d[gi] = w_in;
      end else begin : g_chain
        assign w_slot_d[gi] = w_slot_q[gi-1];
      end

      pipe_slot #(
        .slot_t(slot_t)
      ) u_slot (
        .clk    (clk),
        .rst    (rst),
        .i_flush(flush_i),
        .i_stall(stall_i),
        .i_d    (w_slot_d[gi]),
        .o_q    (w_slot_q[gi])
      );
    end
  endgenerate

  always_comb begin
    w_load_busy = 1'b0;
    for (int k = 0; k < STAGES; k++) begin
      w_load_busy = w_load_busy | (w_slot_q[k].valid & w_slot_q[k].mem_ctrl.mem_read);
    end
  end

  // Flush takes precedence, so a flushed stall cycle is not counted as stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else if (flush_i) begin
      if (r_flush_cnt != {CNT_W{1'b1}}) begin
        r_flush_cnt <= r_flush_cnt + 1'b1;
      end
    end else if (stall_i) begin
      if (r_stall_cnt != {CNT_W{1'b1}}) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign valid_o      = w_slot_q[STAGES-1].valid;
  assign ctrl_wb_o    = w_slot_q[STAGES-1].ctrl_wb;
  assign mem_write_o  = w_slot_q[STAGES-1].mem_ctrl.mem_write;
  assign mem_read_o   = w_slot_q[STAGES-1].mem_ctrl.mem_read;
  assign alu_result_o = w_slot_q[STAGES-1].alu_result;
  assign store_data_o = w_slot_q[STAGES-1].store_data;
  assign rd_o         = w_slot_q[STAGES-1].rd;
  assign load_busy_o  = w_load_busy;
  assign stall_cnt_o  = r_stall_cnt;
  assign flush_cnt_o  = r_flush_cnt;

endmodule

// File: tb/tb_ex_mem_pipe_stage.sv
// Scoreboard bench: drives a 1-slot and a 3-slot instance with the same stimulus and
// checks both against a history-window reference model every cycle.
module tb_ex_mem_pipe_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0, flush_i = 1'b0, valid_i = 1'b0;
  logic [1:0]  ctrl_wb_i = '0;
  logic        mem_write_i = 1'b0, mem_read_i = 1'b0;
  logic [31:0] alu_result_i = '0, store_data_i = '0;
  logic [4:0]  rd_i = '0;

  logic        v1, mw1, mr1, lb1, v3, mw3, mr3, lb3;
  logic [1:0]  wb1, wb3;
  logic [31:0] alu1, sd1, alu3, sd3;
  logic [4:0]  rd1, rd3;
  logic [15:0] sc1, fc1, sc3, fc3;

  always #5 clk = ~clk;

  ex_mem_pipe_stage #(.STAGES(1)) u1 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .ctrl_wb_i(ctrl_wb_i), .mem_write_i(mem_write_i), .mem_read_i(mem_read_i),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i), .rd_i(rd_i),
    .valid_o(v1), .ctrl_wb_o(wb1), .mem_write_o(mw1), .mem_read_o(mr1),
    .alu_result_o(alu1), .store_data_o(sd1), .rd_o(rd1), .load_busy_o(lb1),
    .stall_cnt_o(sc1), .flush_cnt_o(fc1));

  ex_mem_pipe_stage #(.STAGES(3)) u3 (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i), .valid_i(valid_i),
    .ctrl_wb_i(ctrl_wb_i), .mem_write_i(mem_write_i), .mem_read_i(mem_read_i),
    .alu_result_i(alu_result_i), .store_data_i(store_data_i), .rd_i(rd_i),
    .valid_o(v3), .ctrl_wb_o(wb3), .mem_write_o(mw3), .mem_read_o(mr3),
    .alu_result_o(alu3), .store_data_o(sd3), .rd_o(rd3), .load_busy_o(lb3),
    .stall_cnt_o(sc3), .flush_cnt_o(fc3));

  typedef struct {
    logic        v;
    logic [1:0]  wb;
    logic        mw;
    logic        mr;
    logic [31:0] alu;
    logic [31:0] sd;
    logic [4:0]  rd;
  } ent_t;

  typedef struct {
    ent_t o1;
    logic lb1;
    ent_t o3;
    logic lb3;
    int   sc;
    int   fc;
    bit   verbose;
  } exp_t;

  // hist holds the last 4 accepted entries, newest at the back.
  ent_t hist[$];
  exp_t exp_q[$];
  int   m_sc = 0, m_fc = 0;
  int   errors = 0, checks = 0, cyc = 0;
  bit   verbose = 1'b1;

  function automatic logic [73:0] pack(ent_t e);
    return {e.v, e.wb, e.mw, e.mr, e.alu, e.sd, e.rd};
  endfunction

  task automatic chk(string nm, logic [79:0] act, logic [79:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h required %h", nm, cyc, act, req);
    end
  endtask

  task automatic cycle();
    ent_t g, z;
    exp_t x;
    z = '{default: '0};
    @(posedge clk);
    if (rst) begin
      hist.delete();
      repeat (4) hist.push_back(z);
      m_sc = 0;
      m_fc = 0;
    end else if (flush_i) begin
      foreach (hist[i]) begin
        hist[i].v = 1'b0; hist[i].wb = '0; hist[i].mw = 1'b0; hist[i].mr = 1'b0;
      end
      if (m_fc < 65535) m_fc++;
    end else if (stall_i) begin
      if (m_sc < 65535) m_sc++;
    end else begin
      g.v   = valid_i;
      g.wb  = valid_i ? ctrl_wb_i : 2'b00;
      g.mw  = valid_i & mem_write_i;
      g.mr  = valid_i & mem_read_i;
      g.alu = alu_result_i;
      g.sd  = store_data_i;
      g.rd  = rd_i;
      hist.push_back(g);
      void'(hist.pop_front());
    end
    x.o1  = hist[3];
    x.lb1 = hist[3].v & hist[3].mr;
    x.o3  = hist[1];
    x.lb3 = 1'b0;
    for (int i = 1; i < 4; i++) x.lb3 |= hist[i].v & hist[i].mr;
    x.sc = m_sc;
    x.fc = m_fc;
    x.verbose = verbose;
    exp_q.push_back(x);
    cyc++;
    #1;
  endtask

  task automatic drive(input bit v, input bit [1:0] wb, input bit mw, input bit mr,
                       input bit [31:0] alu, input bit [31:0] sd, input bit [4:0] rd,
                       input bit st, input bit fl, input bit r);
    valid_i = v; ctrl_wb_i = wb; mem_write_i = mw; mem_read_i = mr;
    alu_result_i = alu; store_data_i = sd; rd_i = rd;
    stall_i = st; flush_i = fl; rst = r;
    cycle();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 32'hDEAD0000 + i, 0, 5'(i), 0, 0, 0);
  endtask

  initial begin : monitor
    exp_t x;
    ent_t a1, a3;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        x = exp_q.pop_front();
        a1 = '{v: v1, wb: wb1, mw: mw1, mr: mr1, alu: alu1, sd: sd1, rd: rd1};
        a3 = '{v: v3, wb: wb3, mw: mw3, mr: mr3, alu: alu3, sd: sd3, rd: rd3};
        chk("u1_slot", 80'(pack(a1)), 80'(pack(x.o1)));
        chk("u3_slot", 80'(pack(a3)), 80'(pack(x.o3)));
        chk("u1_load_busy", 80'(lb1), 80'(x.lb1));
        chk("u3_load_busy", 80'(lb3), 80'(x.lb3));
        chk("u1_stall_cnt", 80'(sc1), 80'(x.sc));
        chk("u3_stall_cnt", 80'(sc3), 80'(x.sc));
        chk("u1_flush_cnt", 80'(fc1), 80'(x.fc));
        chk("u3_flush_cnt", 80'(fc3), 80'(x.fc));
        if (x.verbose)
          $display("cycle %0d: u1 v=%0b rd=%0d alu=%h wb=%0d mw=%0b | u3 v=%0b rd=%0d alu=%h wb=%0d mw=%0b | busy=%0b/%0b stall=%0d flush=%0d",
                   cyc, v1, rd1, alu1, wb1, mw1, v3, rd3, alu3, wb3, mw3, lb1, lb3, sc1, fc1);
      end
    end
  end

  initial begin : stimulus
    // reset
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
    // single load, then bubbles: latency 1 vs 3
    drive(1, 2'b01, 0, 1, 32'h12345678, 32'h0, 5, 0, 0, 0);
    idle(4);
    // stall for 4 cycles with changing inputs
    drive(1, 2'b10, 0, 0, 32'hA1, 32'hB1, 1, 0, 0, 0);
    drive(1, 2'b11, 0, 1, 32'hA2, 32'hB2, 2, 0, 0, 0);
    for (int i = 0; i < 4; i++) drive(1, 2'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom, 5'($urandom), 1, 0, 0);
    idle(4);
    // store in flight, then flush together with stall
    drive(1, 2'b01, 1, 0, 32'hC0, 32'h570E, 7, 0, 0, 0);
    drive(1, 2'b11, 1, 1, 32'hC1, 32'h5711, 8, 1, 1, 0);
    idle(3);
    // bubble carrying store and write-back control
    drive(0, 2'b11, 1, 0, 32'hB0B, 32'h1234, 9, 0, 0, 0);
    idle(3);
    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      drive(($urandom % 4) != 0, 2'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
            5'($urandom), ($urandom % 100) < 15, ($urandom % 100) < 5, ($urandom % 100) < 2);
    end
    // stall counter saturation, then reset while still stalled
    idle(2);
    verbose = 1'b0;
    for (int i = 0; i < 65540; i++) drive(1, 2'b11, 1, 1, 32'hFACE, 32'hFEED, 3, 1, 0, 0);
    verbose = 1'b1;
    drive(1, 2'b11, 1, 1, 32'hFACE, 32'hFEED, 3, 1, 0, 0);
    drive(1, 2'b11, 1, 1, 32'hFACE, 32'hFEED, 3, 1, 0, 1);
    idle(4);
    repeat (5) @(negedge clk);
    chk("scoreboard_drained", 80'(exp_q.size()), 80'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
